// File: rtl/sdram_phy.sv
// rtl/sdram_phy.sv - pin-side SDRAM I/O stage: registered command/data pins, DQ drive enable, read re-timing
module sdram_phy #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 13,
  parameter int BANK_W      = 2,
  parameter int CAS_LATENCY = 2,
  parameter int BURST_LEN   = 1,
  parameter int RD_EXTRA    = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ctl_cmd_valid,
  input  logic [2:0]          ctl_cmd,
  input  logic [ADDR_W-1:0]   ctl_addr,
  input  logic [BANK_W-1:0]   ctl_bank,
  input  logic [DATA_W/8-1:0] ctl_dqm,
  input  logic                ctl_cke,
  input  logic [DATA_W-1:0]   ctl_wdata,
  output logic [DATA_W-1:0]   ctl_rdata,
  output logic                ctl_rdata_valid,
  output logic                err_conflict,
  output logic                io_sdram_clk,
  output logic                io_sdram_cke,
  output logic                io_sdram_cs_n,
  output logic                io_sdram_ras_n,
  output logic                io_sdram_cas_n,
  output logic                io_sdram_we_n,
  output logic [ADDR_W-1:0]   io_sdram_addr,
  output logic [BANK_W-1:0]   io_sdram_bank,
  output logic [DATA_W/8-1:0] io_sdram_dqm,
  output logic [DATA_W-1:0]   io_sdram_dataOut,
  output logic                io_sdram_output_en,
  input  logic [DATA_W-1:0]   io_dqIn
);
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_DESEL = 3'b111;
  localparam int RD_DLY = 1 + CAS_LATENCY + RD_EXTRA;
  localparam int VLD_W  = RD_DLY + BURST_LEN;
  localparam int BUS_W  = CAS_LATENCY + BURST_LEN + 1;
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  // Bit p of a window register marks "busy p cycles from now"; reads insert a burst-long run of ones.
  localparam logic [VLD_W-1:0] VLD_INS = {{BURST_LEN{1'b1}}, {RD_DLY{1'b0}}};
  localparam logic [BUS_W-1:0] BUS_INS = {1'b0, {BURST_LEN{1'b1}}, {CAS_LATENCY{1'b0}}};
  localparam logic [BUS_W-1:0] BUS_CHK = {{CAS_LATENCY{1'b0}}, {BURST_LEN{1'b1}}, 1'b0};

  logic              is_read;
  logic              is_write;
  logic [CNT_W-1:0]  wr_left;
  logic [VLD_W-1:0]  vld_sr;
  logic [BUS_W-1:0]  bus_sr;
  logic [DATA_W-1:0] rd_pipe [RD_EXTRA+1];

  assign is_read      = ctl_cmd_valid && (ctl_cmd == CMD_READ);
  assign is_write     = ctl_cmd_valid && (ctl_cmd == CMD_WRITE);
  assign io_sdram_clk = ~clock & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_sdram_cke     <= 1'b0;
      io_sdram_cs_n    <= 1'b1;
      io_sdram_ras_n   <= 1'b1;
      io_sdram_cas_n   <= 1'b1;
      io_sdram_we_n    <= 1'b1;
      io_sdram_addr    <= '0;
      io_sdram_bank    <= '0;
      io_sdram_dqm     <= '1;
      io_sdram_dataOut <= '0;
    end else begin
      io_sdram_cke     <= ctl_cke;
      io_sdram_cs_n    <= ~ctl_cmd_valid;
      {io_sdram_ras_n, io_sdram_cas_n, io_sdram_we_n} <= ctl_cmd_valid ? ctl_cmd : CMD_DESEL;
      io_sdram_addr    <= ctl_addr;
      io_sdram_bank    <= ctl_bank;
      io_sdram_dqm     <= ctl_dqm;
      io_sdram_dataOut <= ctl_wdata;
    end
  end

  // A new WRITE reloads the beat count, so back-to-back bursts keep the drive continuous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_sdram_output_en <= 1'b0;
      wr_left            <= '0;
    end else if (is_write) begin
      io_sdram_output_en <= 1'b1;
      wr_left            <= CNT_W'(BURST_LEN - 1);
    end else if (wr_left != '0) begin
      io_sdram_output_en <= 1'b1;
      wr_left            <= wr_left - CNT_W'(1);
    end else begin
      io_sdram_output_en <= 1'b0;
    end
  end

  // The write drives pins in the next BURST_LEN cycles, i.e. bus_sr bits 1..BURST_LEN before shifting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_sr       <= '0;
      bus_sr       <= '0;
      err_conflict <= 1'b0;
      for (int i = 0; i <= RD_EXTRA; i++) rd_pipe[i] <= '0;
    end else begin
      vld_sr <= (vld_sr >> 1) | (is_read ? VLD_INS : '0);
      bus_sr <= (bus_sr >> 1) | (is_read ? BUS_INS : '0);
      if (is_write && |(bus_sr & BUS_CHK)) err_conflict <= 1'b1;
      rd_pipe[0] <= io_dqIn;
      for (int i = 1; i <= RD_EXTRA; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign ctl_rdata_valid = vld_sr[0];
  assign ctl_rdata       = rd_pipe[RD_EXTRA];
endmodule

// File: tb/tb_sdram_phy.sv
// tb/tb_sdram_phy.sv - bench for sdram_phy: cycle-indexed model of two configurations plus directed checks
module tb_sdram_phy;
  localparam int NC  = 256;
  localparam int INF = 1 << 30;
  localparam logic [2:0] RD = 3'b101, WR = 3'b100, NOP = 3'b111, ACT = 3'b011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctl_cmd_valid = 1'b0;
  logic [2:0]  ctl_cmd = 3'b111;
  logic [12:0] ctl_addr = '0;
  logic [1:0]  ctl_bank = '0;
  logic [1:0]  ctl_dqm = 2'b11;
  logic        ctl_cke = 1'b0;
  logic [15:0] ctl_wdata = '0;
  logic [15:0] io_dqIn = '0;

  logic [15:0] a_rdata, b_rdata, a_dout, b_dout;
  logic [12:0] a_addr, b_addr;
  logic [1:0]  a_bank, b_bank, a_dqm, b_dqm;
  logic a_rvld, a_err, a_sclk, a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_oe;
  logic b_rvld, b_err, b_sclk, b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_oe;

  sdram_phy #(.DATA_W(16), .ADDR_W(13), .BANK_W(2), .CAS_LATENCY(2), .BURST_LEN(1), .RD_EXTRA(1)) dut_a (
    .clock(clock), .reset(reset), .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr),
    .ctl_bank(ctl_bank), .ctl_dqm(ctl_dqm), .ctl_cke(ctl_cke), .ctl_wdata(ctl_wdata), .ctl_rdata(a_rdata),
    .ctl_rdata_valid(a_rvld), .err_conflict(a_err), .io_sdram_clk(a_sclk), .io_sdram_cke(a_cke),
    .io_sdram_cs_n(a_cs_n), .io_sdram_ras_n(a_ras_n), .io_sdram_cas_n(a_cas_n), .io_sdram_we_n(a_we_n),
    .io_sdram_addr(a_addr), .io_sdram_bank(a_bank), .io_sdram_dqm(a_dqm), .io_sdram_dataOut(a_dout),
    .io_sdram_output_en(a_oe), .io_dqIn(io_dqIn));

  sdram_phy #(.DATA_W(16), .ADDR_W(13), .BANK_W(2), .CAS_LATENCY(3), .BURST_LEN(4), .RD_EXTRA(0)) dut_b (
    .clock(clock), .reset(reset), .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd(ctl_cmd), .ctl_addr(ctl_addr),
    .ctl_bank(ctl_bank), .ctl_dqm(ctl_dqm), .ctl_cke(ctl_cke), .ctl_wdata(ctl_wdata), .ctl_rdata(b_rdata),
    .ctl_rdata_valid(b_rvld), .err_conflict(b_err), .io_sdram_clk(b_sclk), .io_sdram_cke(b_cke),
    .io_sdram_cs_n(b_cs_n), .io_sdram_ras_n(b_ras_n), .io_sdram_cas_n(b_cas_n), .io_sdram_we_n(b_we_n),
    .io_sdram_addr(b_addr), .io_sdram_bank(b_bank), .io_sdram_dqm(b_dqm), .io_sdram_dataOut(b_dout),
    .io_sdram_output_en(b_oe), .io_dqIn(io_dqIn));

  always #5 clock = ~clock;

  // Model: per-configuration expectations indexed by absolute cycle number.
  int cl_p[2] = '{2, 3};
  int bl_p[2] = '{1, 4};
  int re_p[2] = '{1, 0};
  bit m_oe   [2][NC];
  bit m_vld  [2][NC];
  bit m_busy [2][NC];
  int m_src  [2][NC];
  int err_from [2] = '{INF, INF};
  logic [15:0] wd_hist [NC];
  logic [15:0] dq_hist [NC];
  logic        e_cs_n, e_cke, e_rst, e_sclk;
  logic [2:0]  e_cmd;
  logic [12:0] e_addr;
  logic [1:0]  e_bank, e_dqm;
  logic        g_cke = 1'b0;
  logic [1:0]  g_dqm = 2'b11;
  int cyc = -1;
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
    end
  endtask

  task automatic clear_from(int c);
    for (int d = 0; d < 2; d++) begin
      for (int t = c; t < NC; t++) begin
        m_oe[d][t] = 1'b0; m_vld[d][t] = 1'b0; m_busy[d][t] = 1'b0;
      end
      err_from[d] = INF;
    end
  endtask

  task automatic note_cmd(int c, logic [2:0] cmd);
    for (int d = 0; d < 2; d++) begin
      if (cmd == RD) begin
        for (int k = 0; k < bl_p[d]; k++) begin
          int p, v;
          p = c + 1 + cl_p[d] + k;
          v = c + 2 + cl_p[d] + re_p[d] + k;
          if (p < NC) m_busy[d][p] = 1'b1;
          if (v < NC) begin m_vld[d][v] = 1'b1; m_src[d][v] = p; end
        end
      end else if (cmd == WR) begin
        bit hit;
        hit = 1'b0;
        for (int k = 1; k <= bl_p[d]; k++) begin
          if (c + k < NC) begin
            if (m_busy[d][c+k]) hit = 1'b1;
            m_oe[d][c+k] = 1'b1;
          end
        end
        if (hit && err_from[d] > c + 1) err_from[d] = c + 1;
      end
    end
  endtask

  task automatic run(bit rh, bit pulse, bit v, logic [2:0] cmd, logic [1:0] bank, logic [12:0] addr,
                     logic [15:0] wd, logic [15:0] dq);
    bit r;
    @(posedge clock); #1;
    cyc++;
    r = reset || rh || pulse;
    if (r) begin
      clear_from(cyc);
      e_cs_n = 1'b1; e_cmd = 3'b111; e_cke = 1'b0; e_addr = '0; e_bank = '0; e_dqm = 2'b11;
    end else begin
      e_cs_n = ~ctl_cmd_valid; e_cmd = ctl_cmd_valid ? ctl_cmd : 3'b111;
      e_cke = ctl_cke; e_addr = ctl_addr; e_bank = ctl_bank; e_dqm = ctl_dqm;
    end
    e_rst = r;
    e_sclk = ~rh;
    if (pulse) begin reset = 1'b1; #2; reset = 1'b0; end
    else reset = rh;
    ctl_cmd_valid = v; ctl_cmd = cmd; ctl_bank = bank; ctl_addr = addr;
    ctl_dqm = g_dqm; ctl_cke = g_cke; ctl_wdata = wd; io_dqIn = dq;
    wd_hist[cyc] = wd;
    dq_hist[cyc] = dq;
    if (v && !rh) note_cmd(cyc, cmd);
  endtask

  task automatic idle(logic [15:0] dq);
    run(1'b0, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h3C00 ^ 16'(cyc), dq);
  endtask

  task automatic at_mid();
    @(negedge clock); #1;
  endtask

  task automatic cmp_dut(int d, logic cs_n, logic ras_n, logic cas_n, logic we_n, logic cke, logic [12:0] addr,
                         logic [1:0] bank, logic [1:0] dqm, logic [15:0] dout, logic oe, logic rvld,
                         logic [15:0] rdata, logic err, logic sclk);
    chk("cs_n", d, 32'(cs_n), 32'(e_cs_n));
    chk("cmd", d, 32'({ras_n, cas_n, we_n}), 32'(e_cmd));
    chk("cke", d, 32'(cke), 32'(e_cke));
    chk("addr", d, 32'(addr), 32'(e_addr));
    chk("bank", d, 32'(bank), 32'(e_bank));
    chk("dqm", d, 32'(dqm), 32'(e_dqm));
    chk("sdram_clk", d, 32'(sclk), 32'(e_sclk));
    chk("output_en", d, 32'(oe), 32'(m_oe[d][cyc]));
    if (m_oe[d][cyc]) chk("wdata", d, 32'(dout), 32'(wd_hist[cyc-1]));
    chk("rdata_valid", d, 32'(rvld), 32'(m_vld[d][cyc]));
    if (m_vld[d][cyc]) chk("rdata", d, 32'(rdata), 32'(dq_hist[m_src[d][cyc]]));
    chk("err_conflict", d, 32'(err), 32'(cyc >= err_from[d]));
    if (e_rst) begin
      chk("rst_rdata", d, 32'(rdata), 32'h0);
      chk("rst_dataOut", d, 32'(dout), 32'h0);
    end
  endtask

  always @(negedge clock) begin
    if (cyc >= 0 && cyc < NC) begin
      cmp_dut(0, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_cke, a_addr, a_bank, a_dqm, a_dout, a_oe, a_rvld,
              a_rdata, a_err, a_sclk);
      cmp_dut(1, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_cke, b_addr, b_bank, b_dqm, b_dout, b_oe, b_rvld,
              b_rdata, b_err, b_sclk);
    end
  end

  initial begin
    int first;
    int seen;
    logic [15:0] q[$];

    // Reset held, released with cke low, then cke request
    repeat (3) run(1'b1, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    run(1'b0, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    at_mid();
    chk("rel_cs_n", 0, 32'(a_cs_n), 32'h1);
    chk("rel_dqm", 0, 32'(a_dqm), 32'h3);
    chk("rel_oe", 0, 32'(a_oe), 32'h0);
    chk("rel_cke", 0, 32'(a_cke), 32'h0);
    idle(16'h0);
    g_cke = 1'b1;
    idle(16'h0);
    at_mid();
    chk("cke_lag", 0, 32'(a_cke), 32'h0);
    idle(16'h0);
    at_mid();
    chk("cke_rise", 0, 32'(a_cke), 32'h1);

    // Single write, bank 2 / addr 0x155
    g_dqm = 2'b00;
    run(1'b0, 1'b0, 1'b1, WR, 2'd2, 13'h155, 16'hA5A5, 16'h0);
    run(1'b0, 1'b0, 1'b0, NOP, 2'd0, 13'h0, 16'h5A5A, 16'h0);
    at_mid();
    chk("wr_cs_n", 0, 32'(a_cs_n), 32'h0);
    chk("wr_cmd", 0, 32'({a_ras_n, a_cas_n, a_we_n}), 32'h4);
    chk("wr_bank", 0, 32'(a_bank), 32'h2);
    chk("wr_addr", 0, 32'(a_addr), 32'h155);
    chk("wr_data", 0, 32'(a_dout), 32'hA5A5);
    chk("wr_oe", 0, 32'(a_oe), 32'h1);
    idle(16'h0);
    at_mid();
    chk("wr_oe_drop", 0, 32'(a_oe), 32'h0);
    repeat (5) idle(16'h0);

    // Read with one extra capture stage: pin beat in cycle 3 -> valid in cycle 5
    run(1'b1, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    for (int t = 0; t < 9; t++) begin
      run(1'b0, 1'b0, t == 0, (t == 0) ? RD : NOP, 2'd1, 13'h20, 16'(t), (t == 3) ? 16'h1234 : 16'h0);
      at_mid();
      chk("rd_valid_t", 0, 32'(a_rvld), 32'(t == 5));
      if (t == 5) chk("rd_data", 0, 32'(a_rdata), 32'h1234);
    end

    // CL=3 BL=4: reads at 0 and 4 form one contiguous stream of 8 beats
    run(1'b1, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    first = -1;
    for (int t = 0; t < 16; t++) begin
      run(1'b0, 1'b0, (t == 0 || t == 4), (t == 0 || t == 4) ? RD : NOP, 2'd0, 13'(t), 16'(t),
          (t >= 4 && t <= 11) ? 16'(t - 4) : 16'hFFFF);
      at_mid();
      if (b_rvld) begin
        q.push_back(b_rdata);
        if (first < 0) first = t;
      end
    end
    chk("stream_len", 1, 32'(q.size()), 32'd8);
    chk("stream_first", 1, 32'(first), 32'd5);
    for (int k = 0; k < q.size() && k < 8; k++) chk("stream_beat", 1, 32'(q[k]), 32'(k));

    // Write overlapping an outstanding read window sets the sticky flag
    run(1'b1, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    for (int t = 0; t < 7; t++) begin
      run(1'b0, 1'b0, (t == 0 || t == 2), (t == 0) ? RD : ((t == 2) ? WR : NOP), 2'd0, 13'h7,
          16'hBEE0 + 16'(t), 16'h1100 + 16'(t));
      at_mid();
      chk("conflict", 0, 32'(a_err), 32'(t >= 3));
    end
    // Driving right after the last read beat is legal
    run(1'b1, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    for (int t = 0; t < 9; t++) begin
      run(1'b0, 1'b0, (t == 0 || t == 3), (t == 0) ? RD : ((t == 3) ? WR : NOP), 2'd3, 13'h9,
          16'hCAF0 + 16'(t), 16'h2200 + 16'(t));
      at_mid();
      chk("no_conflict", 0, 32'(a_err), 32'h0);
    end

    // Back-to-back bursts with an ACT in between keep the drive continuous
    run(1'b1, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    for (int t = 0; t < 11; t++) begin
      run(1'b0, 1'b0, (t == 0 || t == 2 || t == 4), (t == 2) ? ACT : ((t == 0 || t == 4) ? WR : NOP),
          2'd1, 13'h40 + 13'(t), 16'hD000 + 16'(t), 16'h0);
      at_mid();
      chk("b2b_oe", 1, 32'(b_oe), 32'(t >= 1 && t <= 8));
    end

    // Async reset pulse kills an in-flight read and an active drive
    run(1'b1, 1'b0, 1'b0, NOP, 2'd0, 13'd0, 16'h0, 16'h0);
    seen = 0;
    for (int t = 0; t < 11; t++) begin
      run(1'b0, t == 2, (t == 0 || t == 1), (t == 0) ? RD : ((t == 1) ? WR : NOP), 2'd0, 13'h3,
          16'hE000 + 16'(t), 16'h4400 + 16'(t));
      at_mid();
      if (t == 2) chk("pulse_oe", 0, 32'(a_oe), 32'h0);
      if (a_rvld) seen++;
    end
    chk("pulse_no_valid", 0, 32'(seen), 32'h0);

    repeat (3) idle(16'h0);
    @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
